stamp_request_arbiter: RTL and testbench
========================================

Name: stamp_request_arbiter

Overview:
- Shares the free-running 64-bit timestamp counter between NUM_QUEUES requesters, one per queue.
- A request pulse latches the counter value into that queue's capture slot in the cycle the request arrives.
- Pending stamps are then serialized onto one tagged output stream using a round-robin arbiter and a valid/ready handshake.
- Sits between the stamp counter output and the per-queue packet stamping/logging logic; overruns are counted.

Parameters:
- NUM_QUEUES, 8, number of requesters; must satisfy NUM_QUEUES <= 2**QID_WIDTH.
- QID_WIDTH, 3, width of the queue-id tag.
- COUNTER_WIDTH, 64, width of the timestamp value.
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  single clock; all logic runs on its rising edge.
- reset  in  1  synchronous, active-high.
- counter_val  in  COUNTER_WIDTH  live timestamp from the counter, same clock domain.
- stamp_req  in  NUM_QUEUES  per-queue request; each cycle a bit is high counts as one request.
- stamp_pending  out  NUM_QUEUES  capture slot i holds an unsent stamp.
- out_data  out  COUNTER_WIDTH  captured timestamp.
- out_qid  out  QID_WIDTH  queue index of out_data.
- out_valid  out  1  output register holds a stamp.
- out_rdy  in  1  consumer accepts; transfer occurs when out_valid && out_rdy.
- drop_count  out  DROP_CNT_WIDTH  requests rejected because their slot was occupied.

Behaviour:
- Reset values: stamp_pending=0, out_valid=0, out_data=0, out_qid=0, drop_count=0, last_grant=NUM_QUEUES-1 so queue 0 wins first.
- Reset asserted mid-operation: all pending and held stamps are discarded; outputs take reset values on the next edge.
- Capture:
  - stamp_req[i]=1 with slot i free (see free-slot rule) -> cap[i]<=counter_val, pending[i]<=1.
  - Slot i is free if pending[i]=0, or if slot i is being loaded into the output register this same cycle.
  - stamp_req[i]=1 with slot i occupied and not being loaded -> request dropped; cap[i] is unchanged; drop_count increments.
  - drop_count saturates at all-ones.
  - Several requests dropped in one cycle add their count, still saturating.
- Load condition: load happens when (state IDLE) or (state HOLD and out_rdy=1), and the registered pending vector is nonzero.
  - Requests arriving in the same cycle are not eligible for that load.
- Load action:
  - sel = first set pending bit searching from (last_grant+1) mod NUM_QUEUES upward, with wrap-around.
  - out_data<=cap[sel], out_qid<=sel, out_valid<=1, pending[sel]<=0 (unless recaptured the same cycle), last_grant<=sel.
- FSM, two states:
  - IDLE (out_valid=0): on load -> HOLD; otherwise stay.
  - HOLD (out_valid=1): out_data/out_qid held stable while out_rdy=0.
  - HOLD with out_rdy=1: load next -> stay HOLD (back-to-back); nothing pending -> IDLE, out_valid<=0.
- Latency: request at cycle t -> stamp_pending at t+1 -> out_valid at t+2 (IDLE, no contention). Sustained throughput is one stamp per cycle while out_rdy=1.
- Captured value is counter_val at the request cycle, independent of grant delay.
- stamp_pending reflects the registered pending vector.

Optional Feature:
- Macro STAMP_ARB_STRICT_PRIO_EN.
- Defined: selection is strict priority, lowest set index wins; last_grant is unused.
- Undefined (default): round-robin as above.
- Capture, drop and handshake behaviour are identical in both builds.

Test Plan:
- Single request: counter_val increments by 64 per cycle from 0x1000. stamp_req[3] at the cycle counter_val=0x1040, out_rdy=1 -> out_valid two cycles later with out_data=0x1040, out_qid=3; valid drops next cycle.
- All 8 requests in one cycle (counter_val=0x2000), out_rdy=1 -> qids 0..7 on 8 consecutive cycles, each out_data=0x2000, drop_count=0.
- Back-pressure:
  - Load q5, hold out_rdy=0 for 10 cycles -> out_data/out_qid unchanged, out_valid stays 1.
  - Pulse stamp_req[5] twice during the hold -> first request accepted, second dropped, drop_count=1.
  - Then release out_rdy -> two q5 stamps delivered in order.
- Recapture at load: stamp_req[2] in the same cycle slot 2 is loaded to output -> new capture accepted, pending[2]=1 afterwards, no drop.
- Fairness:
  - Queues 0 and 1 re-request immediately after each grant, out_rdy=1 -> grants alternate 0,1,0,1.
  - With STAMP_ARB_STRICT_PRIO_EN defined, same stimulus -> q0 wins whenever pending.
- Reset mid-operation and saturation:
  - Reset while in HOLD with 4 slots pending -> next cycle out_valid=0, stamp_pending=0, drop_count=0.
  - 70000 drops on a blocked slot -> drop_count=0xFFFF.

Source files
------------

// File: rtl/stamp_request_arbiter.sv
// stamp_request_arbiter: captures the shared timestamp per queue on request and serializes pending stamps onto one tagged valid/ready stream
//   clk, reset            : single clock, synchronous active-high reset
//   counter_val           : live timestamp sampled on request
//   stamp_req             : per-queue request pulses
//   stamp_pending         : capture slot holds an unsent stamp
//   out_data/out_qid      : granted stamp and its queue index
//   out_valid/out_rdy     : output handshake
//   drop_count            : saturating count of requests refused because the slot was occupied
//   STAMP_ARB_STRICT_PRIO_EN : when defined, lowest pending index wins instead of round-robin
module stamp_request_arbiter #(
  parameter int NUM_QUEUES     = 8,
  parameter int QID_WIDTH      = 3,
  parameter int COUNTER_WIDTH  = 64,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [COUNTER_WIDTH-1:0]  counter_val,
  input  logic [NUM_QUEUES-1:0]     stamp_req,
  output logic [NUM_QUEUES-1:0]     stamp_pending,
  output logic [COUNTER_WIDTH-1:0]  out_data,
  output logic [QID_WIDTH-1:0]      out_qid,
  output logic                      out_valid,
  input  logic                      out_rdy,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0]                r_state;
  logic [NUM_QUEUES-1:0]     r_pending;
  logic [COUNTER_WIDTH-1:0]  r_cap [NUM_QUEUES];
  logic [COUNTER_WIDTH-1:0]  r_out_data;
  logic [QID_WIDTH-1:0]      r_out_qid;
  logic [DROP_CNT_WIDTH-1:0] r_drop;
  logic [QID_WIDTH-1:0]      w_sel;
  logic                      w_load;
  logic [NUM_QUEUES-1:0]     w_load_vec;
  logic [NUM_QUEUES-1:0]     w_accept;
  logic [NUM_QUEUES-1:0]     w_drop;
  logic [DROP_CNT_WIDTH:0]   w_drop_n;
  logic [DROP_CNT_WIDTH:0]   w_sum;
`ifdef STAMP_ARB_STRICT_PRIO_EN
  always_comb begin
    w_sel = '0;
    for (int k = NUM_QUEUES - 1; k >= 0; k--)
      if (r_pending[QID_WIDTH'(k)]) w_sel = QID_WIDTH'(k);
  end
`else
  logic [QID_WIDTH-1:0] r_last_grant;
  // Scan the search order backwards so the earliest candidate after last_grant is written last.
  always_comb begin
    w_sel = '0;
    for (int k = NUM_QUEUES - 1; k >= 0; k--)
      if (r_pending[QID_WIDTH'((int'(r_last_grant) + 1 + k) % NUM_QUEUES)])
        w_sel = QID_WIDTH'((int'(r_last_grant) + 1 + k) % NUM_QUEUES);
  end
  always_ff @(posedge clk) begin
    if (reset) r_last_grant <= QID_WIDTH'(NUM_QUEUES - 1);
    else if (w_load) r_last_grant <= w_sel;
  end
`endif
  assign w_load     = ((r_state == IDLE) || out_rdy) && |r_pending;
  assign w_load_vec = w_load ? (NUM_QUEUES'(1) << w_sel) : '0;
  // A slot leaving for the output this cycle may be refilled in the same cycle.
  assign w_accept   = stamp_req & (~r_pending | w_load_vec);
  assign w_drop     = stamp_req & r_pending & ~w_load_vec;
  always_comb begin
    w_drop_n = '0;
    for (int i = 0; i < NUM_QUEUES; i++)
      w_drop_n = w_drop_n + (DROP_CNT_WIDTH + 1)'(w_drop[i]);
  end
  assign w_sum = {1'b0, r_drop} + w_drop_n;
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_QUEUES; i++)
      if (w_accept[i]) r_cap[i] <= counter_val;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_out_data <= '0;
      r_out_qid  <= '0;
      r_drop     <= '0;
    end else begin
      r_pending <= (r_pending & ~w_load_vec) | w_accept;
      r_drop    <= w_sum[DROP_CNT_WIDTH] ? '1 : w_sum[DROP_CNT_WIDTH-1:0];
      if (w_load) begin
        r_out_data <= r_cap[w_sel];
        r_out_qid  <= w_sel;
        r_state    <= HOLD;
      end else if (out_rdy) r_state <= IDLE;
    end
  end
  assign stamp_pending = r_pending;
  assign out_data      = r_out_data;
  assign out_qid       = r_out_qid;
  assign out_valid     = (r_state == HOLD);
  assign drop_count    = r_drop;
endmodule

// File: tb/tb_stamp_request_arbiter.sv
// tb_stamp_request_arbiter: directed self-checking bench for stamp_request_arbiter
module tb_stamp_request_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] counter_val;
  logic [7:0]  stamp_req;
  logic [7:0]  stamp_pending;
  logic [63:0] out_data;
  logic [2:0]  out_qid;
  logic        out_valid;
  logic        out_rdy;
  logic [15:0] drop_count;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] v1, v2, v3, v4;
  int          exp_q;
  stamp_request_arbiter dut (
    .clk(clk), .reset(reset), .counter_val(counter_val), .stamp_req(stamp_req),
    .stamp_pending(stamp_pending), .out_data(out_data), .out_qid(out_qid),
    .out_valid(out_valid), .out_rdy(out_rdy), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    counter_val = counter_val + 64'd64;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1; stamp_req = '0; out_rdy = 1'b0; counter_val = '0;
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pending", 64'(stamp_pending), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_qid", 64'(out_qid), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b0;
    counter_val = 64'h1000;
    tick();
    stamp_req = 8'h08; out_rdy = 1'b1;
    tick();
    stamp_req = '0;
    chk("single_pend", 64'(stamp_pending), 64'h08);
    chk("single_nv", 64'(out_valid), 64'd0);
    tick();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", out_data, 64'h1040);
    chk("single_qid", 64'(out_qid), 64'd3);
    tick();
    chk("single_drop_valid", 64'(out_valid), 64'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    counter_val = 64'h2000; stamp_req = 8'hFF;
    tick();
    stamp_req = '0;
    chk("all_pend", 64'(stamp_pending), 64'hFF);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("all_valid", 64'(out_valid), 64'd1);
      chk("all_qid", 64'(out_qid), 64'(k));
      chk("all_data", out_data, 64'h2000);
    end
    tick();
    chk("all_idle", 64'(out_valid), 64'd0);
    chk("all_drop", 64'(drop_count), 64'd0);
    out_rdy = 1'b0; stamp_req = 8'h20; v1 = counter_val;
    tick();
    stamp_req = '0;
    chk("bp_pend", 64'(stamp_pending), 64'h20);
    tick();
    chk("bp_load_valid", 64'(out_valid), 64'd1);
    chk("bp_load_data", out_data, v1);
    chk("bp_load_pend", 64'(stamp_pending), 64'h00);
    for (int i = 0; i < 10; i++) begin
      stamp_req = (i == 2 || i == 5) ? 8'h20 : 8'h00;
      if (i == 2) v2 = counter_val;
      tick();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", out_data, v1);
      chk("bp_hold_qid", 64'(out_qid), 64'd5);
    end
    stamp_req = '0;
    chk("bp_drop", 64'(drop_count), 64'd1);
    chk("bp_pend2", 64'(stamp_pending), 64'h20);
    out_rdy = 1'b1;
    tick();
    chk("bp_b2b_valid", 64'(out_valid), 64'd1);
    chk("bp_b2b_data", out_data, v2);
    chk("bp_b2b_qid", 64'(out_qid), 64'd5);
    tick();
    chk("bp_end", 64'(out_valid), 64'd0);
    stamp_req = 8'h04; v3 = counter_val;
    tick();
    chk("rc_pend", 64'(stamp_pending), 64'h04);
    stamp_req = 8'h04; v4 = counter_val;
    tick();
    stamp_req = '0;
    chk("rc_data", out_data, v3);
    chk("rc_qid", 64'(out_qid), 64'd2);
    chk("rc_pend2", 64'(stamp_pending), 64'h04);
    chk("rc_drop", 64'(drop_count), 64'd1);
    tick();
    chk("rc_data2", out_data, v4);
    chk("rc_valid2", 64'(out_valid), 64'd1);
    tick();
    chk("rc_idle", 64'(out_valid), 64'd0);
    stamp_req = 8'h03;
    tick();
    for (int k = 0; k < 6; k++) begin
`ifdef STAMP_ARB_STRICT_PRIO_EN
      exp_q = 0;
`else
      exp_q = k % 2;
`endif
      stamp_req = 8'(1 << exp_q);
      tick();
      chk("fair_qid", 64'(out_qid), 64'(exp_q));
      chk("fair_pend", 64'(stamp_pending), 64'h03);
    end
    stamp_req = '0;
    chk("fair_drop", 64'(drop_count), 64'd1);
    tick(); tick(); tick(); tick();
    chk("drain_idle", 64'(out_valid), 64'd0);
    out_rdy = 1'b0; stamp_req = 8'h1F;
    tick();
    stamp_req = '0;
    tick();
    chk("mid_valid", 64'(out_valid), 64'd1);
    chk("mid_pend4", 64'($countones(stamp_pending)), 64'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_pend", 64'(stamp_pending), 64'd0);
    chk("mid_rst_drop", 64'(drop_count), 64'd0);
    stamp_req = 8'h0F;
    tick(); tick();
    chk("sat_drop3", 64'(drop_count), 64'd3);
    tick();
    chk("sat_drop7", 64'(drop_count), 64'd7);
    for (int i = 0; i < 97; i++) tick();
    chk("sat_drop395", 64'(drop_count), 64'd395);
    for (int i = 0; i < 17000; i++) tick();
    chk("sat_max", 64'(drop_count), 64'hFFFF);
    tick();
    chk("sat_hold", 64'(drop_count), 64'hFFFF);
    chk("sat_qid", 64'(out_qid), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
